euclid_norm_seq: RTL

Sequential, parametrised Euclidean-norm engine. It computes floor(sqrt(x² + y²)) for two unsigned W-bit operands using a start/busy/done handshake. It uses only shift-add arithmetic: a serial multiplier plus a digit-by-digit square root, with no `*` operator and no combinational loops. It sits behind the Tiny Tapeout top-level wrapper: operands come from `ui_in`/`uio_in`, and results are muxed onto `uo_out`. A `mode` input selects a sum-of-squares-only fast path.

---
 rtl/euclid_norm_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/euclid_norm_seq.sv
// ---------------------------------------------------------------------------
// euclid_norm_seq
//   Sequential Euclidean-norm engine: sumsq = x*x + y*y and
//   root = floor(sqrt(sumsq)), built from shift-add steps only.
//   Squares are formed one operand bit per cycle into a shared accumulator.
//   The root comes from a restoring digit-by-digit square root, one result
//   bit per cycle.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   ena    : clock enable, every register holds while low
//   start  : request, sampled only in IDLE while ena=1
//   mode   : 0 = full norm, 1 = sum of squares only (latched at accept)
//   x, y   : unsigned W-bit operands (latched at accept)
//   busy   : high while a computation is in flight
//   done   : one-enabled-cycle completion pulse
//   sumsq  : x^2 + y^2, held until the next completion
//   root   : floor(sqrt(sumsq)), held until the next full-norm completion
//
// Handshake: a request is accepted on a rising edge where the engine is
//   in IDLE, ena=1 and start=1. busy rises after that edge and falls on the
//   edge that raises done. start is ignored while busy, so nothing queues.
//   Because done is raised with the FSM already back in IDLE, a start that
//   is present while done=1 is accepted. Operands may change freely after
//   the accept edge.
// ---------------------------------------------------------------------------
module euclid_norm_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   sumsq,
    output logic [W:0]     root
);

    localparam int AW = 2 * W + 1;       // accumulator width
    localparam int RW = 2 * W + 2;       // radicand width (even number of bits)
    localparam int MW = W + 3;           // remainder width
    localparam int CW = $clog2(W + 1);   // counter must hold W

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SQX  = 2'd1,
        S_SQY  = 2'd2,
        S_ROOT = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Latched request
    logic [W-1:0]  opx;
    logic [W-1:0]  opy;
    logic          mode_q;

    // Datapath registers
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [RW-1:0] rad;
    logic [MW-1:0] rem;
    logic [W:0]    q;

    // Control strobes from the output process
    logic          accept;
    logic          sq_step;
    logic          root_step;
    logic          finish;

    logic          last;

    // Shift-add square datapath
    logic [W-1:0]  sq_op;
    logic          sq_bit;
    logic [AW-1:0] acc_add;
    logic [AW-1:0] acc_sum;

    // Square-root datapath
    logic [MW+1:0] rem_sh;
    logic [MW+1:0] trial;
    logic          ge;
    logic [MW-1:0] rem_nx;
    logic [W:0]    q_nx;

    assign last = (cnt == '0);

    // -----------------------------------------------------------------------
    // Square step: add (op << cnt) when bit cnt of the operand is set.
    // -----------------------------------------------------------------------
    always_comb begin
        sq_op   = (state == S_SQY) ? opy : opx;
        sq_bit  = |(sq_op & (W'(1) << cnt));
        acc_add = sq_bit ? ({{(W + 1){1'b0}}, sq_op} << cnt) : '0;
        acc_sum = acc + acc_add;
    end

    // -----------------------------------------------------------------------
    // Root step: bring down the next two radicand bits, then try to subtract
    // (4*q + 1). The result bit is 1 when the trial subtraction does not go
    // negative. Two guard bits on the comparison keep the shifted remainder
    // exact; the stored remainder never needs them.
    // -----------------------------------------------------------------------
    always_comb begin
        rem_sh = {rem, rad[RW-1 -: 2]};
        trial  = {2'b00, q, 2'b01};
        ge     = (rem_sh >= trial);
        rem_nx = ge ? MW'(rem_sh - trial) : rem_sh[MW-1:0];
        q_nx   = {q[W-1:0], ge};
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // The fast path still passes through one ROOT cycle and finishes there,
    // so its completion lands on edge 2W+1 after the accept edge.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start)          state_nx = S_SQX;
            S_SQX:  if (last)           state_nx = S_SQY;
            S_SQY:  if (last)           state_nx = S_ROOT;
            S_ROOT: if (mode_q || last) state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        accept    = 1'b0;
        sq_step   = 1'b0;
        root_step = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: accept = start;
            S_SQX,
            S_SQY:  sq_step = 1'b1;
            S_ROOT: begin
                root_step = 1'b1;
                finish    = mode_q || last;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            sumsq  <= '0;
            root   <= '0;
            opx    <= '0;
            opy    <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            rad    <= '0;
            rem    <= '0;
            q      <= '0;
        end else if (ena) begin
            // done is a single-enabled-cycle pulse
            done <= finish;

            if (accept) begin
                opx    <= x;
                opy    <= y;
                mode_q <= mode;
                acc    <= '0;
                cnt    <= CW'(W - 1);
                busy   <= 1'b1;
            end

            if (sq_step) begin
                acc <= acc_sum;
                if (!last) begin
                    cnt <= cnt - CW'(1);
                end else if (state == S_SQX) begin
                    cnt <= CW'(W - 1);
                end else begin
                    // Hand the finished sum to the root stage: W+1 iterations.
                    cnt <= CW'(W);
                    rad <= {1'b0, acc_sum};
                    rem <= '0;
                    q   <= '0;
                end
            end

            if (root_step) begin
                rad <= rad << 2;
                rem <= rem_nx;
                q   <= q_nx;
                cnt <= cnt - CW'(1);
            end

            if (finish) begin
                busy  <= 1'b0;
                sumsq <= acc;
                if (!mode_q) begin
                    root <= q_nx;
                end
            end
        end
    end

endmodule
